// File: rtl/leg_output_fifo.sv
// Byte FIFO between the CPU output strobe and a valid/ready consumer.
// Bytes offered while full (with no pop that cycle) are dropped and counted.
module leg_output_fifo #(
  parameter int UUID  = 0,
  parameter     NAME  = "",
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arch_output_enable,
  input  logic [7:0]                 arch_output_value,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0) || (UUID < 0)) begin : g_bad_param
    $error("leg_output_fifo %s (uuid %0d): DEPTH must be a power of two in 2..256", NAME, UUID);
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          out_valid_q;
  logic          full_q;
  logic          overflow_q;
  logic [7:0]    drop_count_q;

  // Handshake: a byte transfers on every rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and the
  // head byte holds steady until it is accepted.
  logic          pop;
  logic          push;
  logic          drop;
  logic [CW-1:0] count_d;

  always_comb begin
    pop  = out_valid_q & out_ready;
    push = arch_output_enable & (~full_q | pop);
    drop = arch_output_enable & full_q & ~pop;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q     <= count_d;
      out_valid_q <= (count_d != '0);
      full_q      <= (count_d == DEPTH_C);
      // A drop in the same cycle as a clear wins: the flag stays set and
      // the counter restarts at one.
      if (drop) begin
        overflow_q <= 1'b1;
        if (ovf_clr) begin
          drop_count_q <= 8'd1;
        end else if (drop_count_q != 8'hFF) begin
          drop_count_q <= drop_count_q + 8'd1;
        end
      end else if (ovf_clr) begin
        overflow_q   <= 1'b0;
        drop_count_q <= 8'h00;
      end
    end
  end

  // Storage is not reset; entries are only visible through a valid head.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr_q] <= arch_output_value;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_valid_q ? mem[rd_ptr_q] : 8'h00;
  assign count      = count_q;
  assign full       = full_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_leg_output_fifo.sv
// Directed and randomized checks of leg_output_fifo against a queue-based
// reference model of the byte FIFO and its overflow bookkeeping.
module tb_leg_output_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arch_output_enable = 1'b0;
  logic [7:0] arch_output_value = 8'h00;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] drop_count;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  bit         m_ovf;
  int         m_dc;

  leg_output_fifo #(.UUID(3), .NAME("tb_fifo"), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .arch_output_enable (arch_output_enable),
    .arch_output_value  (arch_output_value),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .out_ready          (out_ready),
    .count              (count),
    .full               (full),
    .overflow           (overflow),
    .drop_count         (drop_count),
    .ovf_clr            (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".out_valid"},  32'(out_valid),  32'(n != 0));
    check({tag, ".out_data"},   32'(out_data),   (n != 0) ? 32'(exp_q[0]) : 32'h0);
    check({tag, ".count"},      32'(count),      32'(n));
    check({tag, ".full"},       32'(full),       32'(n == DEPTH));
    check({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
    check({tag, ".drop_count"}, 32'(drop_count), 32'(m_dc));
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic cycle(input string tag, input bit en, input logic [7:0] val,
                       input bit rdy, input bit clr);
    bit pop;
    bit drop;
    arch_output_enable = en;
    arch_output_value  = val;
    out_ready          = rdy;
    ovf_clr            = clr;
    pop  = (exp_q.size() != 0) && rdy;
    drop = en && (exp_q.size() == DEPTH) && !pop;
    if (pop) void'(exp_q.pop_front());
    if (en && !drop) exp_q.push_back(val);
    if (drop) begin
      m_ovf = 1'b1;
      m_dc  = clr ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_dc  = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    arch_output_enable = 1'b0;
    arch_output_value  = 8'h00;
    out_ready          = 1'b0;
    ovf_clr            = 1'b0;
  endtask

  initial begin
    exp_q.delete();
    m_ovf = 1'b0;
    m_dc  = 0;

    // Reset state while rst is held low
    #12;
    check_all("reset");
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset");

    // Single push, then pop
    cycle("single_push", 1'b1, 8'hA5, 1'b0, 1'b0);
    check("single_push.data_a5", 32'(out_data), 32'hA5);
    cycle("single_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("single_pop.data_00", 32'(out_data), 32'h00);

    // Fill, then pop three while pushing three so both pointers wrap
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("fill.full", 32'(full), 32'h1);
    check("fill.count", 32'(count), 32'h8);
    cycle("hold_head", 1'b0, 8'h00, 1'b0, 1'b0);
    check("hold_head.data", 32'(out_data), 32'h01);
    for (int i = 9; i <= 11; i++) cycle("wrap_pushpop", 1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 4; i <= 11; i++) begin
      check("wrap_order", 32'(out_data), 32'(i));
      cycle("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Overflow: three drops, contents preserved, then clear
    for (int i = 1; i <= 8; i++) cycle("ovf_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("ovf_drop", 1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf.flag", 32'(overflow), 32'h1);
    check("ovf.drop_count", 32'(drop_count), 32'h3);
    cycle("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr.flag", 32'(overflow), 32'h0);
    check("ovf_clr.drop_count", 32'(drop_count), 32'h0);
    cycle("ovf_drop_and_clr", 1'b1, 8'hFF, 1'b0, 1'b1);
    check("ovf_set_wins.drop_count", 32'(drop_count), 32'h1);
    cycle("ovf_clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous push/pop while full: 0x77 ends up last
    cycle("full_pushpop", 1'b1, 8'h77, 1'b1, 1'b0);
    check("full_pushpop.count", 32'(count), 32'h8);
    for (int i = 0; i < 7; i++) cycle("full_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    check("full_drain.last", 32'(out_data), 32'h77);
    cycle("full_drain_last", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous push/pop while empty: no spurious pop
    cycle("empty_pushpop", 1'b1, 8'h3C, 1'b1, 1'b0);
    check("empty_pushpop.count", 32'(count), 32'h1);
    check("empty_pushpop.data", 32'(out_data), 32'h3C);
    cycle("empty_pushpop_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-operation with five entries stored
    for (int i = 0; i < 5; i++) cycle("pre_reset", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    exp_q.delete();
    m_ovf = 1'b0;
    m_dc  = 0;
    check_all("async_reset");
    arch_output_enable = 1'b1;
    arch_output_value  = 8'h99;
    out_ready          = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_held");
    #3 rst = 1'b1;
    idle_inputs();
    cycle("after_reset_push", 1'b1, 8'h5A, 1'b0, 1'b0);
    check("after_reset_push.count", 32'(count), 32'h1);
    check("after_reset_push.data", 32'(out_data), 32'h5A);
    cycle("after_reset_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // drop_count saturation
    for (int i = 1; i <= 8; i++) cycle("sat_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle("sat_drop", 1'b1, 8'(i), 1'b0, 1'b0);
    check("sat.drop_count", 32'(drop_count), 32'hFF);
    check("sat.flag", 32'(overflow), 32'h1);
    cycle("sat_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle("random",
            ($urandom_range(0, 99) < 60),
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 5));
    end

    idle_inputs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
